// File: rtl/serial_subtractor_24bit_pkg.sv
// rtl/serial_subtractor_24bit_pkg.sv - shared width default and FSM state encoding
package serial_subtractor_24bit_pkg;

  localparam int DEFAULT_WIDTH = 24;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_subtractor_24bit_full_subtractor.sv
// rtl/serial_subtractor_24bit_full_subtractor.sv - combinational 1-bit full subtractor
module serial_subtractor_24bit_full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_24bit.sv
// rtl/serial_subtractor_24bit.sv - bit-serial LSB-first subtractor with start/busy/done handshake
module serial_subtractor_24bit
  import serial_subtractor_24bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] res_sh;
  logic             br;
  logic [CW-1:0]    count;
  logic             d;
  logic             bout;
  logic [WIDTH-1:0] res_next;

  serial_subtractor_24bit_full_subtractor u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (br),
    .d    (d),
    .bout (bout)
  );

  // Result fills from the MSB side; after WIDTH shifts bit 0 of the operands sits at bit 0.
  assign res_next = {d, res_sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      br         <= 1'b0;
      count      <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= borrow_in;
            count <= '0;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next[WIDTH-1:1];
          br     <= bout;
          count  <= count + CW'(1);
          if (count == LAST) begin
            diff       <= res_next;
            borrow_out <= bout;
            state      <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_subtractor_24bit.sv
// tb/tb_serial_subtractor_24bit.sv - randomized self-checking bench with arithmetic reference model
module tb_serial_subtractor_24bit;

  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         borrow_in;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;

  int tests = 0;
  int fails = 0;

  serial_subtractor_24bit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;

  // Reference: remaining edges of the current op, and the full-width arithmetic result.
  int         rem    = 0;
  logic       done_m = 1'b0;
  logic [W:0] pend   = '0;
  logic [W-1:0] mdiff = '0;
  logic       mbo    = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem    <= 0;
      done_m <= 1'b0;
      pend   <= '0;
      mdiff  <= '0;
      mbo    <= 1'b0;
    end else if (rem == 0) begin
      done_m <= 1'b0;
      if (start) begin
        pend <= {1'b0, a} - {1'b0, b} - (W+1)'(borrow_in);
        rem  <= W;
      end
    end else begin
      rem <= rem - 1;
      if (rem == 1) begin
        done_m <= 1'b1;
        mbo    <= pend[W];
        mdiff  <= pend[W-1:0];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("model_busy", 32'(busy), 32'(rem > 0));
      check("model_done", 32'(done), 32'(done_m));
      check("model_diff", 32'(diff), 32'(mdiff));
      check("model_borrow_out", 32'(borrow_out), 32'(mbo));
    end
  end

  // Called #1 after an edge; start is accepted at the next edge.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
    a = ia; b = ib; borrow_in = ibin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
  endtask

  task automatic wait_done(output int edges, output int busy_cnt);
    edges = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && edges < 200) begin
      if (busy === 1'b1) busy_cnt++;
      @(posedge clk); #1;
      edges++;
    end
    if (done !== 1'b1) begin
      tests++; fails++;
      $display("FAIL wait_done: timeout after %0d edges", edges);
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ibin, input logic [W-1:0] ed, input logic eb);
    int edges, bc;
    issue(ia, ib, ibin);
    wait_done(edges, bc);
    check({name, "_latency"}, 32'(edges), 32'(W));
    check({name, "_diff"}, 32'(diff), 32'(ed));
    check({name, "_borrow"}, 32'(borrow_out), 32'(eb));
  endtask

  initial begin
    int edges, bc, nd;
    logic [W-1:0] ra, rb, rd;
    logic rbin;
    logic [W:0] sum;

    start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_diff", 32'(diff), 32'd0);
    check("reset_borrow", 32'(borrow_out), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic subtraction with latency and busy window.
    issue(24'h000002, 24'h000001, 1'b0);
    wait_done(edges, bc);
    check("t1_latency", 32'(edges), 32'd24);
    check("t1_busy_cycles", 32'(bc), 32'd24);
    check("t1_diff", 32'(diff), 32'h000001);
    check("t1_borrow", 32'(borrow_out), 32'd0);
    @(posedge clk); #1;
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_diff_hold", 32'(diff), 32'h000001);

    run_op("t2", 24'h000000, 24'h000001, 1'b0, 24'hFFFFFF, 1'b1);
    run_op("t3a", 24'h800000, 24'h000001, 1'b1, 24'h7FFFFE, 1'b0);
    run_op("t3b", 24'h123456, 24'h123456, 1'b1, 24'hFFFFFF, 1'b1);
    @(posedge clk); #1;

    // Start while busy is ignored; back-to-back start in the DONE cycle.
    issue(24'h000010, 24'h000003, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    a = 24'hFFFFFF; b = '0; borrow_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(edges, bc);
    check("t4_latency", 32'(edges + 5), 32'd24);
    check("t4_diff", 32'(diff), 32'h00000D);
    check("t4_borrow", 32'(borrow_out), 32'd0);
    issue(24'h000005, 24'h000005, 1'b0);
    wait_done(edges, bc);
    check("t4_b2b_gap", 32'(edges + 1), 32'd25);
    check("t4_b2b_diff", 32'(diff), 32'h000000);
    check("t4_b2b_borrow", 32'(borrow_out), 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset mid-operation.
    issue(24'h00FFFF, 24'h000001, 1'b0);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_diff", 32'(diff), 32'd0);
    check("t5_borrow", 32'(borrow_out), 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    nd = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done === 1'b1) nd++;
    end
    check("t5_no_done", 32'(nd), 32'd0);
    run_op("t5_fresh", 24'h000003, 24'h000001, 1'b0, 24'h000002, 1'b0);

    // Random operations, sometimes back-to-back from the DONE cycle.
    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
      if (i % 8 == 0) rb = ra;
      if (i % 11 == 0) ra = '0;
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
      issue(ra, rb, rbin);
      wait_done(edges, bc);
      rd = diff;
      sum = {1'b0, rd} + {1'b0, rb} + (W+1)'(rbin);
      check("rnd_latency", 32'(edges), 32'd24);
      check("rnd_recover_a", 32'(sum[W-1:0]), 32'(ra));
      check("rnd_borrow", 32'(borrow_out), 32'(({1'b0, ra}) < ({1'b0, rb} + (W+1)'(rbin))));
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
